// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        EMIT
    } state_e;

    // Result width of a neuron: full-precision product plus adder-tree growth.
    function automatic int fc_ow(input int width, input int n_active);
        return width * 2 + $clog2(n_active);
    endfunction

endpackage

// File: rtl/fc_vec_buf.sv
// Input vector register file: one write port, synchronous clear, all entries visible on x.
module fc_vec_buf #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int IDX_W = 7
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic signed [WIDTH-1:0] wdata,
    output logic signed [WIDTH-1:0] x [0:IN-1]
);

    logic signed [WIDTH-1:0] mem_q [0:IN-1];
    logic signed [WIDTH-1:0] mem_d [0:IN-1];

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < IN; i++) mem_d[i] = '0;
        end else if (we) begin
            mem_d[widx] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign x = mem_q;

endmodule

// File: rtl/fc_neuron_seq_ctrl.sv
// Sequencer for one FC layer: loads an input vector, steps through neurons, streams results.
// Optional running argmax over each frame's results when FC_SEQ_ARGMAX_EN is defined.
module fc_neuron_seq_ctrl
    import fc_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int N_OUT  = 10,
    parameter int OW     = fc_ow(WIDTH, IN),
    parameter int SETTLE = 2,
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    output logic signed [WIDTH-1:0] x [0:IN-1],
    output logic [SEL_W-1:0]        nrn_sel,
    input  logic [OW-1:0]           neuron_z,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OW-1:0]           m_data,
    output logic [SEL_W-1:0]        m_idx,
    output logic                    m_last,
    output logic                    busy
`ifdef FC_SEQ_ARGMAX_EN
    ,
    output logic                    am_valid,
    output logic [SEL_W-1:0]        am_idx,
    output logic [OW-1:0]           am_val
`endif
);

    localparam logic [IDX_W-1:0]    WR_LAST  = IDX_W'(IN - 1);
    localparam logic [SEL_W-1:0]    SEL_LAST = SEL_W'(N_OUT - 1);
    localparam logic [SETTLE_W-1:0] SET_LAST = SETTLE_W'(SETTLE - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [SEL_W-1:0]     nrn_sel_q, nrn_sel_d;
    logic [SETTLE_W-1:0]  set_cnt_q, set_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [OW-1:0]        m_data_q, m_data_d;
    logic [SEL_W-1:0]     m_idx_q, m_idx_d;
    logic                 m_last_q, m_last_d;

    logic s_fire, last_beat, settle_done, m_fire;

    assign s_fire      = (state_q == LOAD) && s_valid;
    assign last_beat   = s_fire && (wr_cnt_q == WR_LAST);
    assign settle_done = (state_q == fc_seq_pkg::SETTLE) && (set_cnt_q == SET_LAST);
    assign m_fire      = (state_q == EMIT) && m_valid_q && m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:               if (last_beat)   state_d = fc_seq_pkg::SETTLE;
            fc_seq_pkg::SETTLE: if (settle_done) state_d = EMIT;
            EMIT:               if (m_fire)      state_d = m_last_q ? LOAD : fc_seq_pkg::SETTLE;
            default:                             state_d = LOAD;
        endcase
    end

    always_comb begin
        s_ready = (state_q == LOAD);
        busy    = !((state_q == LOAD) && (wr_cnt_q == '0));
    end

    // Counters and the result register; the result only changes at a capture or a handshake.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        nrn_sel_d = nrn_sel_q;
        set_cnt_d = set_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_idx_d   = m_idx_q;
        m_last_d  = m_last_q;
        if (s_fire) wr_cnt_d = last_beat ? '0 : wr_cnt_q + IDX_W'(1);
        if (last_beat) begin
            nrn_sel_d = '0;
            set_cnt_d = '0;
        end
        if (state_q == fc_seq_pkg::SETTLE) set_cnt_d = set_cnt_q + SETTLE_W'(1);
        if (settle_done) begin
            m_valid_d = 1'b1;
            m_data_d  = neuron_z;
            m_idx_d   = nrn_sel_q;
            m_last_d  = (nrn_sel_q == SEL_LAST);
        end
        if (m_fire) begin
            m_valid_d = 1'b0;
            set_cnt_d = '0;
            if (!m_last_q) nrn_sel_d = nrn_sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            nrn_sel_q <= '0;
            set_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            nrn_sel_q <= nrn_sel_d;
            set_cnt_q <= set_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_idx_q   <= m_idx_d;
            m_last_q  <= m_last_d;
        end
    end

    fc_vec_buf #(
        .WIDTH (WIDTH),
        .IN    (IN),
        .IDX_W (IDX_W)
    ) u_vec_buf (
        .clk   (clk),
        .clr   (!rst_n),
        .we    (s_fire),
        .widx  (wr_cnt_q),
        .wdata (s_data),
        .x     (x)
    );

    assign nrn_sel = nrn_sel_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;

`ifdef FC_SEQ_ARGMAX_EN
    logic             am_valid_q, am_valid_d;
    logic [SEL_W-1:0] am_idx_q, am_idx_d;
    logic [OW-1:0]    am_val_q, am_val_d;

    // The first capture of a frame restarts the tracker; strict compare keeps the lowest index on ties.
    always_comb begin
        am_valid_d = m_fire && m_last_q;
        am_idx_d   = am_idx_q;
        am_val_d   = am_val_q;
        if (settle_done) begin
            if (nrn_sel_q == '0) begin
                am_idx_d = '0;
                am_val_d = neuron_z;
            end else if (neuron_z > am_val_q) begin
                am_idx_d = nrn_sel_q;
                am_val_d = neuron_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            am_valid_q <= 1'b0;
            am_idx_q   <= '0;
            am_val_q   <= '0;
        end else begin
            am_valid_q <= am_valid_d;
            am_idx_q   <= am_idx_d;
            am_val_q   <= am_val_d;
        end
    end

    assign am_valid = am_valid_q;
    assign am_idx   = am_idx_q;
    assign am_val   = am_val_q;
`endif

endmodule
